bcd_count_ctrl: RTL and testbench
=================================

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of cascaded BCD digits (range 1..8).
REQ-002 The block SHALL have parameter PRESCALE, default 10, giving clock cycles per count increment (range 1..1024).
REQ-003 Port clk  in  1  is the single rising-edge clock.
REQ-004 Port rst_asyn_n  in  1  is the reset: asynchronous, active-low.
REQ-005 Port start  in  1  starts, resumes or restarts counting; level-sampled each clk edge.
REQ-006 Port stop  in  1  pauses counting.
REQ-007 Port clear  in  1  returns the block to idle with a zero count.
REQ-008 Port limit_bcd  in  4*NDIG  is the terminal count, packed BCD with digit 0 in bits [3:0], sampled when start is accepted.
REQ-009 Port count_bcd  out  4*NDIG  is the current packed BCD count.
REQ-010 Port running  out  1  is high while the state is RUN.
REQ-011 Port done  out  1  is a one-cycle pulse on entry to DONE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and DONE; command priority is clear > stop > start.
REQ-013 clear in any state SHALL, at the next edge, force IDLE, count_bcd=0 and prescaler=0.
REQ-014 IDLE+start with all limit_bcd digits <=9 SHALL capture the limit, zero the count and prescaler, and enter RUN; running is high after that edge.
REQ-015 IDLE+start with any limit digit >9 SHALL be ignored: state stays IDLE and the limit register is unchanged.
REQ-016 In RUN the prescaler SHALL count 0..PRESCALE-1 and assert an internal tick when it equals PRESCALE-1, wrapping to 0; the first increment occurs PRESCALE cycles after RUN entry; PRESCALE=1 gives a tick every cycle.
REQ-017 On a tick the count SHALL increment in BCD with ripple carry: a digit at 9 goes to 0 and carries; the all-nines count wraps to all-zeros.
REQ-018 If the incremented count equals the captured limit, the block SHALL load that value and enter DONE on the same edge; done=1 and running=0 for the following cycle only.
REQ-019 A captured limit of 0 SHALL mean full range: DONE is entered on the wrap to 0 after 10^NDIG ticks.
REQ-020 RUN+stop SHALL enter PAUSE; an increment due in that cycle is discarded; count and prescaler hold.
REQ-021 PAUSE+start SHALL resume RUN without re-capturing the limit; the prescaler continues from its held value.
REQ-022 DONE SHALL hold count_bcd; DONE+start SHALL behave as IDLE+start (REQ-014/015); stop in IDLE or DONE has no effect.
REQ-023 count_bcd, running and done SHALL be registered outputs; count_bcd never holds a digit >9.

Reset
REQ-024 Asserting rst_asyn_n low SHALL immediately force IDLE, count_bcd=0, running=0, done=0, prescaler=0 and limit register=0, independent of clk.
REQ-025 After release, the first state change SHALL occur no earlier than the first rising clk edge with rst_asyn_n high.

Structure
REQ-026 Package bcd_ctrl_pkg SHALL hold the FSM state enum, constant BCD_MAX=9 and the digit width constant 4.
REQ-027 One sub-module, bcd_digit (inputs inc, clr; outputs a 4-bit digit and carry), SHALL be instantiated NDIG times with carry chained to the next digit's inc.

Verification (NDIG=2, PRESCALE=2)
REQ-028 start with limit 0x12 -> count steps 00,01..09,10,11,12, each held 2 cycles; one done pulse; running=0 afterwards.
REQ-029 limit 0x00, run from 0x98 -> 0x99 then 0x00 with done pulse; 0x09 -> 0x10 carry checked along the way.
REQ-030 stop at count 0x05 for 10 cycles -> count stays 0x05; start -> next increment exactly 2 cycles after resume (prescaler held at 0) or 1 cycle (held at 1).
REQ-031 clear during RUN and during DONE -> count 0x00, IDLE, running=0 after one edge; start with 0x1A -> ignored, stays IDLE.
REQ-032 rst_asyn_n pulsed low mid-RUN between clock edges -> all outputs 0 without waiting for a clk edge; the first increment occurs 2 cycles after a subsequent start.
REQ-033 clear, stop and start asserted together in RUN -> clear wins (IDLE, 0x00); stop and start together in RUN -> PAUSE.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD counter controller.
// Holds the FSM encoding, digit width/limit and the single-digit BCD increment.
package bcd_ctrl_pkg;

  localparam int unsigned DIG_W = 4;
  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [DIG_W-1:0] bcd_inc(input logic [DIG_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: registered digit, updates on the clock after inc/clr.
// Carry is combinational so a full ripple across all decades settles in one cycle.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_asyn_n,
  input  logic             inc,
  input  logic             clr,
  output logic [DIG_W-1:0] digit,
  output logic             carry
);

  always_ff @(posedge clk or negedge rst_asyn_n) begin
    if (!rst_asyn_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= bcd_inc(digit);
    end
  end

  assign carry = inc && (digit == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Prescaled NDIG-decade BCD counter with start/stop/clear control and terminal count.
// All outputs registered; commands take effect on the next clk edge, no handshake.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst_asyn_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [DIG_W*NDIG-1:0] limit_bcd,
  output logic [DIG_W*NDIG-1:0] count_bcd,
  output logic                  running,
  output logic                  done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  state_t                  state;
  logic [PW-1:0]           psc;
  logic [DIG_W*NDIG-1:0]   limit_q;
  logic [DIG_W*NDIG-1:0]   nxt_cnt;
  logic [NDIG:0]           dig_inc;
  logic                    tick;
  logic                    lim_ok;
  logic                    idle_like;
  logic                    accept;
  logic                    inc_en;
  logic                    dig_clr;
  logic                    hit;

  always_comb begin
    lim_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (limit_bcd[i*DIG_W +: DIG_W] > BCD_MAX) lim_ok = 1'b0;
    end
  end

  assign tick       = (psc == PSC_LAST);
  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
  assign accept     = idle_like && start && !stop && !clear && lim_ok;
  assign inc_en     = (state == ST_RUN) && tick && !stop && !clear;
  assign dig_clr    = clear || accept;
  assign dig_inc[0] = inc_en;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_asyn_n (rst_asyn_n),
      .inc        (dig_inc[g]),
      .clr        (dig_clr),
      .digit      (count_bcd[g*DIG_W +: DIG_W]),
      .carry      (dig_inc[g+1])
    );
  end

  // Value the digits will hold after this edge; only meaningful when inc_en is set.
  always_comb begin
    nxt_cnt = count_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_inc[i]) nxt_cnt[i*DIG_W +: DIG_W] = bcd_inc(count_bcd[i*DIG_W +: DIG_W]);
    end
  end

  // A zero limit means full range: terminate on the carry out of the top decade.
  assign hit = (limit_q == '0) ? dig_inc[NDIG] : (nxt_cnt == limit_q);

  always_ff @(posedge clk or negedge rst_asyn_n) begin
    if (!rst_asyn_n) begin
      state   <= ST_IDLE;
      psc     <= '0;
      limit_q <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= ST_IDLE;
        psc     <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              limit_q <= limit_bcd;
              psc     <= '0;
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end else begin
              psc <= tick ? '0 : psc + PW'(1);
              if (tick && hit) begin
                state   <= ST_DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (start && !stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl (NDIG=2, PRESCALE=2): directed scenarios then random commands.
module tb_bcd_count_ctrl;

  localparam int NDIG     = 2;
  localparam int PRESCALE = 2;
  localparam int W        = 4 * NDIG;
  localparam int MODV     = 100;

  logic         clk;
  logic         rst_asyn_n;
  logic         start;
  logic         stop;
  logic         clear;
  logic [W-1:0] limit_bcd;
  logic [W-1:0] count_bcd;
  logic         running;
  logic         done;

  bcd_count_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst_asyn_n (rst_asyn_n),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .limit_bcd  (limit_bcd),
    .count_bcd  (count_bcd),
    .running    (running),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] cnt;
    bit           run;
    bit           dn;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: plain integer count, elapsed cycles since last increment.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;
  mmode_t m_mode;
  int     m_cnt;
  int     m_lim;
  int     m_elapsed;
  bit     m_done;

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r  = 0;
    int sc = 1;
    for (int i = 0; i < NDIG; i++) begin
      r  += int'(v[4*i +: 4]) * sc;
      sc *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_cnt     = 0;
    m_lim     = 0;
    m_elapsed = 0;
    m_done    = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input logic [W-1:0] lim);
    m_done = 1'b0;
    if (c) begin
      m_mode    = M_IDLE;
      m_cnt     = 0;
      m_elapsed = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (s && !p && bcd_ok(lim)) begin
            m_lim     = bcd2int(lim);
            m_cnt     = 0;
            m_elapsed = 0;
            m_mode    = M_RUN;
          end
        end
        M_RUN: begin
          if (p) begin
            m_mode = M_PAUSE;
          end else begin
            m_elapsed++;
            if (m_elapsed == PRESCALE) begin
              m_elapsed = 0;
              m_cnt     = (m_cnt + 1) % MODV;
              if (m_cnt == m_lim) begin
                m_mode = M_DONE;
                m_done = 1'b1;
              end
            end
          end
        end
        M_PAUSE: if (s && !p) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of commands and queue the outputs expected after the next edge.
  task automatic step(input bit s, input bit p, input bit c, input logic [W-1:0] lim);
    exp_t e;
    @(negedge clk);
    start     = s;
    stop      = p;
    clear     = c;
    limit_bcd = lim;
    model_step(s, p, c, lim);
    e.cnt = int2bcd(m_cnt);
    e.run = (m_mode == M_RUN);
    e.dn  = m_done;
    sb.push_back(e);
  endtask

  task automatic run_idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("count",   count_bcd,   e.cnt);
        check("running", W'(running), W'(e.run));
        check("done",    W'(done),    W'(e.dn));
      end
    end
  end

  initial begin
    bit           s;
    bit           p;
    bit           c;
    logic [W-1:0] lim;

    start      = 1'b0;
    stop       = 1'b0;
    clear      = 1'b0;
    limit_bcd  = '0;
    rst_asyn_n = 1'b1;
    #1 rst_asyn_n = 1'b0;
    model_reset();
    #2;
    check("rst_count",   count_bcd,   '0);
    check("rst_running", W'(running), '0);
    check("rst_done",    W'(done),    '0);
    @(negedge clk);
    rst_asyn_n = 1'b1;

    // Count to 12 with two cycles per step, then idle in DONE.
    step(1'b1, 1'b0, 1'b0, 8'h12);
    run_idle(30);

    // Full range: walks through 09->10 and 98->99->00.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run_idle(205);

    // Pause at 05 with prescaler at 0, then again at 06 with prescaler at 1.
    step(1'b1, 1'b0, 1'b0, 8'h50);
    run_idle(10);
    repeat (10) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run_idle(3);
    repeat (10) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run_idle(4);

    // Clear in RUN, clear in DONE, then an invalid limit is refused.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    run_idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h03);
    run_idle(8);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h1A);
    run_idle(4);

    // Simultaneous commands in RUN.
    step(1'b1, 1'b0, 1'b0, 8'h40);
    run_idle(5);
    step(1'b1, 1'b1, 1'b1, 8'h40);
    run_idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h40);
    run_idle(3);
    step(1'b1, 1'b1, 1'b0, 8'h40);
    run_idle(3);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run_idle(4);

    // Asynchronous reset between edges while running.
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    #2 rst_asyn_n = 1'b0;
    model_reset();
    #1;
    check("arst_count",   count_bcd,   '0);
    check("arst_running", W'(running), '0);
    check("arst_done",    W'(done),    '0);
    @(negedge clk);
    rst_asyn_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h07);
    run_idle(6);

    // Random command mix, mostly small valid limits so DONE is reached often.
    repeat (1500) begin
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) == 0) lim = W'($urandom);
      else                           lim = int2bcd($urandom_range(0, 30));
      step(s, p, c, lim);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
